// File: rtl/led_pkg.sv
// Shared types, constants and arbitration helpers for the LED sharing scheduler.
package led_pkg;

    localparam int NREQ  = 4;
    localparam int LED_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam logic [LED_W-1:0] CHASE_0 = 3'b001;
    localparam logic [LED_W-1:0] CHASE_1 = 3'b010;
    localparam logic [LED_W-1:0] CHASE_2 = 3'b100;
    localparam logic [LED_W-1:0] CHASE_3 = 3'b000;

    // Scan downward so the closest asserted requester after 'last' is written last and wins.
    function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last + 2'd1;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx  = last + 2'(k + 1);
            pick = req[idx] ? idx : pick;
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] one_hot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    function automatic logic [LED_W-1:0] pat_sel(input logic [3*NREQ-1:0] pat, input logic [1:0] idx);
        logic [LED_W-1:0] val;
        case (idx)
            2'd0:    val = pat[2:0];
            2'd1:    val = pat[5:3];
            2'd2:    val = pat[8:6];
            2'd3:    val = pat[11:9];
            default: val = 3'b000;
        endcase
        return val;
    endfunction

    function automatic logic [LED_W-1:0] chase_led(input logic [1:0] idx);
        logic [LED_W-1:0] val;
        case (idx)
            2'd0:    val = CHASE_0;
            2'd1:    val = CHASE_1;
            2'd2:    val = CHASE_2;
            2'd3:    val = CHASE_3;
            default: val = CHASE_3;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running divider producing a registered one-cycle tick every DIV_MAX clocks.
module led_tick_gen #(
    parameter int unsigned DIV_MAX = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [31:0] CNT_LAST = 32'(DIV_MAX - 1);

    logic [31:0] cnt_r;
    logic [31:0] cnt_next_s;

    // Next counter value with wrap at the last count.
    always_comb begin
        if (cnt_r == CNT_LAST) begin
            cnt_next_s = 32'd0;
        end else begin
            cnt_next_s = cnt_r + 32'd1;
        end
    end

    // tick is aligned with the cycle in which the counter holds its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 32'd0;
            tick  <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            tick  <= (cnt_next_s == CNT_LAST);
        end
    end

endmodule

// File: rtl/led_share_sched.sv
// Round-robin LED ownership scheduler with timed hold and early release.
// Optional idle chase pattern enabled by defining LED_SHARE_IDLE_CHASE_EN.
module led_share_sched
    import led_pkg::*;
#(
    parameter int unsigned DIV_MAX    = 50_000_000,
    parameter int unsigned HOLD_TICKS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [11:0] pat,
    output logic [3:0]  gnt,
    output logic [2:0]  led,
    output logic        busy,
    output logic        tick
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

    state_t           state_r;
    logic [1:0]       owner_r;
    logic [1:0]       last_owner_r;
    logic [7:0]       hold_cnt_r;
    logic [3:0]       gnt_r;
    logic [LED_W-1:0] led_r;
    logic             busy_r;

    logic             tick_s;
    logic [1:0]       pick_s;
    logic [LED_W-1:0] owner_pat_s;
    logic [LED_W-1:0] idle_led_s;
    logic             exit_s;

    led_tick_gen #(
        .DIV_MAX (DIV_MAX)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // Arbitration pick and the single hold-exit condition (release and timeout merge here).
    always_comb begin
        pick_s      = rr_pick(req, last_owner_r);
        owner_pat_s = pat_sel(pat, owner_r);
        exit_s      = (~req[owner_r]) | (tick_s & (hold_cnt_r == HOLD_LAST));
    end

`ifdef LED_SHARE_IDLE_CHASE_EN
    logic [1:0] chase_idx_r;
    logic [1:0] chase_idx_next_s;

    // Chase index advances on ticks while idle with no request, and snaps back when a grant is issued.
    always_comb begin
        if (state_r == ST_IDLE) begin
            if (req != 4'b0000) begin
                chase_idx_next_s = 2'd0;
            end else if (tick_s) begin
                chase_idx_next_s = chase_idx_r + 2'd1;
            end else begin
                chase_idx_next_s = chase_idx_r;
            end
        end else begin
            chase_idx_next_s = chase_idx_r;
        end
    end

    // Chase index register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chase_idx_r <= 2'd0;
        end else begin
            chase_idx_r <= chase_idx_next_s;
        end
    end

    assign idle_led_s = chase_led(chase_idx_next_s);
`else
    assign idle_led_s = {LED_W{1'b0}};
`endif

    // Scheduler FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= 2'd0;
            last_owner_r <= 2'd3;
            hold_cnt_r   <= 8'd0;
            gnt_r        <= 4'b0000;
            led_r        <= {LED_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req != 4'b0000) begin
                        state_r    <= ST_HOLD;
                        owner_r    <= pick_s;
                        gnt_r      <= one_hot(pick_s);
                        busy_r     <= 1'b1;
                        hold_cnt_r <= 8'd0;
                        led_r      <= {LED_W{1'b0}};
                    end else begin
                        gnt_r  <= 4'b0000;
                        busy_r <= 1'b0;
                        led_r  <= idle_led_s;
                    end
                end
                ST_HOLD: begin
                    if (exit_s) begin
                        state_r      <= ST_IDLE;
                        last_owner_r <= owner_r;
                        gnt_r        <= 4'b0000;
                        busy_r       <= 1'b0;
                        led_r        <= idle_led_s;
                    end else begin
                        led_r <= owner_pat_s;
                        if (tick_s) begin
                            hold_cnt_r <= hold_cnt_r + 8'd1;
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    gnt_r   <= 4'b0000;
                    busy_r  <= 1'b0;
                    led_r   <= {LED_W{1'b0}};
                end
            endcase
        end
    end

    assign gnt  = gnt_r;
    assign led  = led_r;
    assign busy = busy_r;
    assign tick = tick_s;

endmodule

// File: tb/tb_led_share_sched.sv
// Self-checking bench: directed table, corner-case sequences and a randomized run against a behavioural model.
module tb_led_share_sched;

    localparam int DIV_MAX    = 4;
    localparam int HOLD_TICKS = 2;

`ifdef LED_SHARE_IDLE_CHASE_EN
    localparam logic [2:0] IDLE0 = 3'b001;
`else
    localparam logic [2:0] IDLE0 = 3'b000;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [11:0] pat;
    logic [3:0]  gnt;
    logic [2:0]  led;
    logic        busy;
    logic        tick;

    int total;
    int bad;

    // Behavioural model state: owner -1 means nobody holds the LEDs.
    int         m_cnt;
    logic       m_tick;
    int         m_owner;
    int         m_last;
    int         m_held;
    int         m_idx;
    logic [2:0] m_led;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] pat;
        logic [3:0]  gnt;
        logic [2:0]  led;
        logic        busy;
        logic        tick;
    } vec_t;

    vec_t tbl[10];

    led_share_sched #(
        .DIV_MAX    (DIV_MAX),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .pat  (pat),
        .gnt  (gnt),
        .led  (led),
        .busy (busy),
        .tick (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] idle_led(input int idx);
`ifdef LED_SHARE_IDLE_CHASE_EN
        return (idx == 3) ? 3'b000 : 3'(1 << idx);
`else
        return 3'(idx * 0);
`endif
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_tick  = 1'b0;
        m_owner = -1;
        m_last  = 3;
        m_held  = 0;
        m_idx   = 0;
        m_led   = 3'b000;
    endtask

    task automatic model_edge();
        logic pre_tick;
        int   pick;
        pre_tick = m_tick;
        m_cnt    = (m_cnt + 1) % DIV_MAX;
        m_tick   = (m_cnt == DIV_MAX - 1);
        if (m_owner < 0) begin
            if (req != 4'b0000) begin
                pick = -1;
                for (int k = 1; k <= 4; k++) begin
                    if (pick < 0 && req[(m_last + k) % 4]) pick = (m_last + k) % 4;
                end
                m_owner = pick;
                m_held  = 0;
                m_idx   = 0;
                m_led   = 3'b000;
            end else begin
                if (pre_tick) m_idx = (m_idx + 1) % 4;
                m_led = idle_led(m_idx);
            end
        end else if (!req[m_owner] || (pre_tick && m_held == HOLD_TICKS - 1)) begin
            m_last  = m_owner;
            m_owner = -1;
            m_led   = idle_led(m_idx);
        end else begin
            if (pre_tick) m_held++;
            m_led = pat[m_owner*3 +: 3];
        end
    endtask

    task automatic step();
        logic [3:0] e_gnt;
        @(posedge clk);
        model_edge();
        #1;
        e_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        check("model_gnt", 32'(gnt), 32'(e_gnt));
        check("model_led", 32'(led), 32'(m_led));
        check("model_busy", 32'(busy), 32'(m_owner >= 0));
        check("model_tick", 32'(tick), 32'(m_tick));
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_gnt(input logic [3:0] want, input string name);
        for (int i = 0; i < 40; i++) begin
            if (gnt == want) break;
            step();
        end
        check(name, 32'(gnt), 32'(want));
    endtask

    initial begin
        logic [3:0] seen[$];
        int         gaps[$];
        int         zero_run;
        logic [3:0] prev_gnt;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 4'b0000;
        pat   = 12'h000;
        model_reset();

        // Directed single-requester hold/timeout/re-grant sequence.
        tbl[0] = '{4'h1, 12'h005, 4'h1, 3'b000, 1'b1, 1'b0};
        tbl[1] = '{4'h1, 12'h005, 4'h1, 3'b101, 1'b1, 1'b0};
        tbl[2] = '{4'h1, 12'h005, 4'h1, 3'b101, 1'b1, 1'b1};
        tbl[3] = '{4'h1, 12'h005, 4'h1, 3'b101, 1'b1, 1'b0};
        tbl[4] = '{4'h1, 12'h005, 4'h1, 3'b101, 1'b1, 1'b0};
        tbl[5] = '{4'h1, 12'h005, 4'h1, 3'b101, 1'b1, 1'b0};
        tbl[6] = '{4'h1, 12'h005, 4'h1, 3'b101, 1'b1, 1'b1};
        tbl[7] = '{4'h1, 12'h005, 4'h0, IDLE0,  1'b0, 1'b0};
        tbl[8] = '{4'h1, 12'h005, 4'h1, 3'b000, 1'b1, 1'b0};
        tbl[9] = '{4'h1, 12'h005, 4'h1, 3'b101, 1'b1, 1'b0};

        apply_reset();
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            pat = tbl[i].pat;
            step();
            check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            check($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_tick", i), 32'(tick), 32'(tbl[i].tick));
        end

        // All requesters held: order 0,1,2,3,0 with a one-cycle gap between grants.
        apply_reset();
        req      = 4'b1111;
        pat      = 12'hA53;
        prev_gnt = 4'b0000;
        zero_run = 0;
        for (int i = 0; i < 200 && seen.size() < 5; i++) begin
            step();
            if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                seen.push_back(gnt);
                gaps.push_back(zero_run);
            end
            zero_run = (gnt == 4'b0000) ? zero_run + 1 : 0;
            prev_gnt = gnt;
        end
        check("rr_count", 32'(seen.size()), 32'd5);
        for (int i = 0; i < seen.size(); i++) begin
            check($sformatf("rr_order%0d", i), 32'(seen[i]), 32'(4'b0001 << (i % 4)));
            if (i > 0) check($sformatf("rr_gap%0d", i), 32'(gaps[i]), 32'd1);
        end

        // Early release by requester 2; requester 3 follows after the gap.
        apply_reset();
        req = 4'b0100;
        wait_gnt(4'b0100, "rel_grant2");
        req = 4'b1100;
        step();
        req = 4'b1000;
        step();
        check("rel_gnt_drop", 32'(gnt), 32'h0);
        check("rel_busy_drop", 32'(busy), 32'h0);
        step();
        check("rel_grant3", 32'(gnt), 32'(4'b1000));

        // Reset mid-hold aborts; arbitration restarts from requester 0.
        apply_reset();
        req = 4'b0100;
        wait_gnt(4'b0100, "mid_grant2");
        step();
        apply_reset();
        req = 4'b1100;
        step();
        check("post_rst_grant2", 32'(gnt), 32'(4'b0100));

        // Release coinciding with the final-hold tick is a single exit.
        apply_reset();
        req = 4'b0011;
        wait_gnt(4'b0001, "co_grant0");
        for (int i = 0; i < 40; i++) begin
            if (tick && m_owner == 0 && m_held == HOLD_TICKS - 1) break;
            step();
        end
        check("co_aligned", 32'(tick && m_held == HOLD_TICKS - 1), 32'd1);
        req = 4'b0010;
        step();
        check("co_exit_gnt", 32'(gnt), 32'h0);
        step();
        check("co_next_grant1", 32'(gnt), 32'(4'b0010));

        // Randomized traffic against the model.
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            pat = 12'($urandom);
            if ($urandom_range(0, 249) == 0) apply_reset();
            else step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_share_sched.md
LED_SHARE_SCHED -- requirements
Module: led_share_sched

Interface
REQ-001 Parameter DIV_MAX, default 50_000_000: clk cycles per tick; legal range 2..2^32-1.
REQ-002 Parameter HOLD_TICKS, default 4: ticks a granted requester owns the LEDs; legal range 1..255.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  4  per-requester level request for LED ownership; bit i is requester i.
REQ-006 pat  input  12  per-requester LED pattern; pat[3i+2:3i] belongs to requester i.
REQ-007 gnt  output  4  registered one-hot grant; all zero when no owner.
REQ-008 led  output  3  registered LED drive, bit order {LED2,LED1,LED0}.
REQ-009 busy  output  1  registered; 1 while any grant is active.
REQ-010 tick  output  1  registered one-cycle pulse at the tick rate, for debug and test.

Function
REQ-011 Tick counter: 32-bit, counts 0..DIV_MAX-1 and wraps to 0; tick=1 for exactly one cycle when the counter equals DIV_MAX-1; runs free in every state.
REQ-012 FSM states: IDLE, HOLD.
REQ-013 IDLE with req==0: stay; gnt=0, busy=0.
REQ-014 IDLE with req!=0: next edge enters HOLD; grants the first asserted requester, searching round-robin from (last_owner+1) mod 4; gnt, busy and owner all update on the same edge.
REQ-015 last_owner resets to 3, so requester 0 has first priority after reset.
REQ-016 HOLD: led is registered pat[owner], one-cycle latency from pat; a live pattern change is visible on the next edge.
REQ-017 HOLD: hold counter (8 bits) clears on entry and increments on each tick.
REQ-018 HOLD exits to IDLE on the edge where tick=1 and the hold counter equals HOLD_TICKS-1; gnt clears and last_owner=owner on that edge.
REQ-019 HOLD exits to IDLE on the first edge where req[owner]=0 (early release), regardless of tick.
REQ-020 Early release and timeout on the same edge are one exit event.
REQ-021 Exactly one IDLE cycle always separates consecutive grants (re-arbitration gap), including when the same requester is re-granted.
REQ-022 Requests from non-owners during HOLD are ignored until IDLE; no preemption.
REQ-023 Only one gnt bit may be high at any time.

Reset
REQ-024 rst asserted: state=IDLE, gnt=0, led=000, busy=0, tick=0, tick counter=0, hold counter=0, last_owner=3, idle pattern index=0.
REQ-025 rst asserted mid-HOLD aborts the grant immediately; the first arbitration after release restarts from requester 0.

Configuration
REQ-026 Macro LED_SHARE_IDLE_CHASE_EN defined: in IDLE, led steps 001->010->100->000->001 once per tick, index advancing only in IDLE; on entry to HOLD the index resets to 0.
REQ-027 Macro LED_SHARE_IDLE_CHASE_EN undefined: led=000 throughout IDLE; no chase logic is synthesized.

Structure
REQ-028 Shared package led_pkg: state enum (IDLE, HOLD), NREQ=4, LED_W=3, and the chase pattern constants.
REQ-029 The tick generator is a separate sub-module, led_tick_gen (parameter DIV_MAX; ports clk, rst, tick).
REQ-030 The arbiter, FSM and output registers reside in led_share_sched.

Verification (DIV_MAX=4, HOLD_TICKS=2 unless noted)
REQ-031 Reset, then req=0001, pat[2:0]=101 -> gnt=0001 one edge after req; led=101 one edge later; gnt drops on the second tick; one IDLE cycle; re-grant 0001.
REQ-032 req=1111 held -> grant order 0,1,2,3,0, each grant separated by exactly one cycle with gnt=0.
REQ-033 Grant to requester 2; deassert req[2] mid-hold -> gnt=0 on the next edge, busy=0; requester 3 granted after the gap.
REQ-034 rst pulse while gnt=0100 -> all outputs 0 asynchronously; after release, req=1100 grants requester 2 first.
REQ-035 Macro LED_SHARE_IDLE_CHASE_EN defined, req=0 -> led steps 001,010,100,000 on successive ticks; assert req[1] -> chase stops and led shows pat[1]; after release the chase restarts at 001.
REQ-036 Simultaneous tick and owner drop on the final hold tick -> single exit; last_owner updated once; next grant goes to the next requester in round-robin order.
